// File: rtl/conv_window_mac_if.sv
// conv_window_mac_if: beat input bus plus valid/ready partial-sum output bus.
// master = front-end / consumer side, slave = the MAC stage.
interface conv_window_mac_if #(
    parameter int unsigned pixels_in_row = 32,
    parameter int unsigned psum_width    = 24,
    parameter int unsigned weight_width  = 8
);
    logic                                pix_valid;
    logic [pixels_in_row*8-1:0]          re_row1_pixels;
    logic [pixels_in_row*8-1:0]          re_row2_pixels;
    logic [pixels_in_row*8-1:0]          re_row3_pixels;
    logic [9*weight_width-1:0]           weights;
    logic                                stall;
    logic                                out_valid;
    logic                                out_ready;
    logic [pixels_in_row*psum_width-1:0] out_psum;
    logic [15:0]                         out_group_idx;

    modport master (
        output pix_valid, re_row1_pixels, re_row2_pixels, re_row3_pixels, weights, out_ready,
        input  stall, out_valid, out_psum, out_group_idx
    );

    modport slave (
        input  pix_valid, re_row1_pixels, re_row2_pixels, re_row3_pixels, weights, out_ready,
        output stall, out_valid, out_psum, out_group_idx
    );
endinterface

// File: rtl/conv_window_mac.sv
// conv_window_mac: 3x3 / 1x1 window multiply-accumulate across nif input channels.
// Macro CONV_MAC_PSUM_SAT_EN selects saturating accumulation instead of wrap.
module conv_window_mac #(
    parameter int unsigned pixels_in_row = 32,
    parameter int unsigned psum_width    = 24,
    parameter int unsigned weight_width  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       k,
    input  logic [15:0]      nif,
    input  logic             start,
    output logic             busy,
    conv_window_mac_if.slave bus
);
    localparam int unsigned PIX_W = 8;
    localparam int unsigned SUM_W = 21;

    // Zero-extended pixel times signed weight, at window-sum width.
    function automatic logic signed [SUM_W-1:0] mac_term(input logic [PIX_W-1:0] p,
                                                         input logic [weight_width-1:0] w);
        logic signed [SUM_W-1:0] sp;
        logic signed [SUM_W-1:0] sw;
        sp = SUM_W'($signed({1'b0, p}));
        sw = SUM_W'($signed(w));
        return sp * sw;
    endfunction

    function automatic logic [psum_width-1:0] lane_add(input logic [psum_width-1:0] a,
                                                       input logic [psum_width-1:0] b);
`ifdef CONV_MAC_PSUM_SAT_EN
        logic [psum_width:0] s;
        s = {a[psum_width-1], a} + {b[psum_width-1], b};
        if (s[psum_width] != s[psum_width-1])
            return s[psum_width] ? {1'b1, {(psum_width-1){1'b0}}} : {1'b0, {(psum_width-1){1'b1}}};
        return s[psum_width-1:0];
`else
        return a + b;
`endif
    endfunction

    logic                                r_nif_lock;
    logic [15:0]                         r_nif;
    logic [15:0]                         r_chan_cnt;
    logic                                r_a_valid;
    logic                                r_a_last;
    logic                                r_a_first;
    logic [pixels_in_row*SUM_W-1:0]      r_a_sum;
    logic [pixels_in_row*psum_width-1:0] r_acc;
    logic                                r_out_valid;
    logic [pixels_in_row*psum_width-1:0] r_out_psum;
    logic [15:0]                         r_group_idx;

    logic                                w_k1;
    logic [15:0]                         w_nif_in;
    logic [15:0]                         w_nif;
    logic                                w_chan_last;
    logic                                w_freeze;
    logic                                w_accept;
    logic                                w_b_fire;
    logic                                w_load;
    logic                                w_drain;
    logic [pixels_in_row*SUM_W-1:0]      w_win;
    logic [pixels_in_row*psum_width-1:0] w_acc_next;

    assign w_k1        = (k == 4'd1);
    assign w_nif_in    = (nif == 16'd0) ? 16'd1 : nif;
    // Before the first start there is no latched count, so follow the live input.
    assign w_nif       = r_nif_lock ? r_nif : w_nif_in;
    assign w_chan_last = (r_chan_cnt >= w_nif - 16'd1);
    assign w_freeze    = r_a_valid & r_a_last & r_out_valid & ~bus.out_ready;
    assign w_accept    = bus.pix_valid & en & ~bus.stall;
    assign w_b_fire    = en & r_a_valid & ~w_freeze;
    assign w_load      = w_b_fire & r_a_last;
    assign w_drain     = en & r_out_valid & bus.out_ready;

    // Per-lane window sum; the top two lanes have no full 3-wide window.
    for (genvar j = 0; j < pixels_in_row; j++) begin : g_lane
        logic signed [SUM_W-1:0] w_one;
        logic signed [SUM_W-1:0] w_three;
        assign w_one = mac_term(bus.re_row1_pixels[j*PIX_W+:PIX_W], bus.weights[0+:weight_width]);
        if (j + 3 <= pixels_in_row) begin : g_win
            always_comb begin
                w_three = '0;
                for (int c = 0; c < 3; c++) begin
                    w_three = w_three
                        + mac_term(bus.re_row1_pixels[(j+c)*PIX_W+:PIX_W],
                                   bus.weights[c*weight_width+:weight_width])
                        + mac_term(bus.re_row2_pixels[(j+c)*PIX_W+:PIX_W],
                                   bus.weights[(3+c)*weight_width+:weight_width])
                        + mac_term(bus.re_row3_pixels[(j+c)*PIX_W+:PIX_W],
                                   bus.weights[(6+c)*weight_width+:weight_width]);
                end
            end
        end else begin : g_edge
            assign w_three = '0;
        end
        assign w_win[j*SUM_W+:SUM_W] = w_k1 ? w_one : w_three;
    end

    always_comb begin
        w_acc_next = '0;
        for (int j = 0; j < pixels_in_row; j++) begin
            w_acc_next[j*psum_width+:psum_width] =
                lane_add(r_a_first ? '0 : r_acc[j*psum_width+:psum_width],
                         psum_width'($signed(r_a_sum[j*SUM_W+:SUM_W])));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nif_lock  <= 1'b0;
            r_nif       <= 16'd1;
            r_chan_cnt  <= '0;
            r_a_valid   <= 1'b0;
            r_a_last    <= 1'b0;
            r_a_first   <= 1'b0;
            r_a_sum     <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_psum  <= '0;
            r_group_idx <= '0;
        end else if (start) begin
            r_nif_lock  <= 1'b1;
            r_nif       <= w_nif_in;
            r_chan_cnt  <= '0;
            r_a_valid   <= 1'b0;
            r_a_last    <= 1'b0;
            r_a_first   <= 1'b0;
            r_a_sum     <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_psum  <= '0;
            r_group_idx <= '0;
        end else if (en) begin
            if (!w_freeze) begin
                r_a_valid <= w_accept;
                if (w_accept) begin
                    r_a_sum    <= w_win;
                    r_a_last   <= w_chan_last;
                    r_a_first  <= (r_chan_cnt == 16'd0);
                    r_chan_cnt <= w_chan_last ? 16'd0 : r_chan_cnt + 16'd1;
                end
            end
            if (w_b_fire) begin
                if (r_a_last) begin
                    r_acc      <= '0;
                    r_out_psum <= w_acc_next;
                end else begin
                    r_acc <= w_acc_next;
                end
            end
            if (w_load)
                r_out_valid <= 1'b1;
            else if (w_drain)
                r_out_valid <= 1'b0;
            if (w_drain)
                r_group_idx <= r_group_idx + 16'd1;
        end
    end

    assign bus.stall         = en & w_freeze;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_psum      = r_out_psum;
    assign bus.out_group_idx = r_group_idx;
    assign busy              = r_a_valid | (r_chan_cnt != 16'd0);
endmodule

// File: tb/tb_conv_window_mac.sv
// tb_conv_window_mac: directed and randomized checks of conv_window_mac against
// a per-beat arithmetic model of window sums and group accumulation.
module tb_conv_window_mac;
    localparam int unsigned NP = 32;
    localparam int unsigned PW = 24;
    localparam int unsigned WW = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  k = 4'd3;
    logic [15:0] nif = 16'd1;
    logic        busy;

    conv_window_mac_if bus ();

    conv_window_mac dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .k     (k),
        .nif   (nif),
        .start (start),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     pix [3][NP];
    int     wt  [9];
    longint acc [NP];

    function automatic longint win(input int kk, input int j);
        longint s = 0;
        if (kk == 1) return longint'(pix[0][j]) * wt[0];
        if (j > NP - 3) return 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += longint'(pix[r][j+c]) * wt[r*3+c];
        return s;
    endfunction

    function automatic longint fold(input longint a, input longint b);
        longint s = a + b;
`ifdef CONV_MAC_PSUM_SAT_EN
        if (s > (longint'(1) << (PW-1)) - 1) s = (longint'(1) << (PW-1)) - 1;
        if (s < -(longint'(1) << (PW-1)))    s = -(longint'(1) << (PW-1));
`else
        s = s & ((longint'(1) << PW) - 1);
        if (s >= (longint'(1) << (PW-1))) s -= (longint'(1) << PW);
`endif
        return s;
    endfunction

    function automatic void clear_acc();
        for (int j = 0; j < NP; j++) acc[j] = 0;
    endfunction

    function automatic void model_add(input int kk);
        for (int j = 0; j < NP; j++) acc[j] = fold(acc[j], win(kk, j));
    endfunction

    function automatic logic [NP*PW-1:0] pack_exp();
        logic [NP*PW-1:0] v;
        for (int j = 0; j < NP; j++) v[j*PW+:PW] = PW'(acc[j]);
        return v;
    endfunction

    task automatic rand_pix();
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < NP; j++) pix[r][j] = int'($urandom_range(255, 0));
        for (int i = 0; i < 9; i++) wt[i] = int'($urandom_range(255, 0)) - 128;
    endtask

    task automatic fill(input int p, input int w);
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < NP; j++) pix[r][j] = p;
        for (int i = 0; i < 9; i++) wt[i] = w;
    endtask

    task automatic load_bus();
        for (int j = 0; j < NP; j++) begin
            bus.re_row1_pixels[j*8+:8] = 8'(pix[0][j]);
            bus.re_row2_pixels[j*8+:8] = 8'(pix[1][j]);
            bus.re_row3_pixels[j*8+:8] = 8'(pix[2][j]);
        end
        for (int i = 0; i < 9; i++) bus.weights[i*WW+:WW] = WW'(wt[i]);
    endtask

    task automatic pulse_start(input int kk, input int nn);
        @(negedge clk);
        k = 4'(kk); nif = 16'(nn); start = 1'b1; bus.pix_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; start = 1'b0;
        bus.pix_valid = 1'b0; bus.out_ready = 1'b1;
        bus.re_row1_pixels = '0; bus.re_row2_pixels = '0; bus.re_row3_pixels = '0; bus.weights = '0;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_tests++; if (bus.out_psum !== '0) begin n_fail++; $display("FAIL reset_out_psum got %h want 0", bus.out_psum); end
        n_tests++; if (bus.out_group_idx !== 16'd0) begin n_fail++; $display("FAIL reset_group_idx got %0d want 0", bus.out_group_idx); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall); end
        reset = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got valid=%b busy=%b want 0 0", bus.out_valid, busy); end
    endtask

    task automatic test_k3_ones();
        logic [NP*PW-1:0] e;
        pulse_start(3, 1);
        bus.out_ready = 1'b1;
        fill(1, 1); clear_acc(); model_add(3); e = pack_exp();
        @(negedge clk); load_bus(); bus.pix_valid = 1'b1; #1;
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL ones_stall got %b want 0", bus.stall); end
        @(negedge clk); bus.pix_valid = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ones_early_valid got %b want 0", bus.out_valid); end
        @(negedge clk);
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ones_valid got %b want 1", bus.out_valid); end
        n_tests++; if (bus.out_psum !== e) begin n_fail++; $display("FAIL ones_psum got %h want %h", bus.out_psum, e); end
        n_tests++; if (bus.out_psum[0+:PW] !== 24'd9 || bus.out_psum[31*PW+:PW] !== 24'd0) begin
            n_fail++; $display("FAIL ones_lanes got l0=%0d l31=%0d want 9 0", bus.out_psum[0+:PW], bus.out_psum[31*PW+:PW]); end
        n_tests++; if (bus.out_group_idx !== 16'd0) begin n_fail++; $display("FAIL ones_idx0 got %0d want 0", bus.out_group_idx); end
        @(negedge clk);
        n_tests++; if (bus.out_valid !== 1'b0 || bus.out_group_idx !== 16'd1) begin
            n_fail++; $display("FAIL ones_drain got valid=%b idx=%0d want 0 1", bus.out_valid, bus.out_group_idx); end
    endtask

    task automatic run_single_group(input string nm, input int kk, input int nn, input longint lane_j, input longint lane_v);
        logic [NP*PW-1:0] e;
        int stalled = 0;
        int got = 0;
        clear_acc();
        for (int b = 0; b < nn; b++) begin
            @(negedge clk); load_bus(); bus.pix_valid = 1'b1; #1;
            if (bus.stall) stalled++;
            model_add(kk);
        end
        e = pack_exp();
        @(negedge clk); bus.pix_valid = 1'b0;
        for (int t = 0; t < 6; t++) begin
            if (bus.out_valid) begin
                got++;
                if (got == 1) begin
                    n_tests++; if (bus.out_psum !== e) begin n_fail++; $display("FAIL %s_psum got %h want %h", nm, bus.out_psum, e); end
                    n_tests++; if (bus.out_psum[lane_j*PW+:PW] !== PW'(lane_v)) begin
                        n_fail++; $display("FAIL %s_lane got %0d want %0d", nm, $signed(bus.out_psum[lane_j*PW+:PW]), lane_v); end
                end
            end
            @(negedge clk);
        end
        n_tests++; if (got != 1) begin n_fail++; $display("FAIL %s_outputs got %0d want 1", nm, got); end
        n_tests++; if (stalled != 0) begin n_fail++; $display("FAIL %s_stall got %0d stalled beats want 0", nm, stalled); end
    endtask

    task automatic test_k3_neg();
        pulse_start(3, 4);
        bus.out_ready = 1'b1;
        fill(2, -3);
        run_single_group("neg", 3, 4, 0, -216);
    endtask

    task automatic test_k1();
        pulse_start(1, 2);
        bus.out_ready = 1'b1;
        rand_pix();
        for (int j = 0; j < NP; j++) pix[0][j] = j;
        wt[0] = 5;
        run_single_group("k1", 1, 2, 31, 310);
    endtask

    task automatic test_freeze();
        logic [NP*PW-1:0] e1, e2;
        pulse_start(3, 1);
        bus.out_ready = 1'b0;
        rand_pix(); clear_acc(); model_add(3); e1 = pack_exp();
        @(negedge clk); load_bus(); bus.pix_valid = 1'b1;
        rand_pix(); clear_acc(); model_add(3); e2 = pack_exp();
        @(negedge clk); load_bus(); #1;
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL frz_second_accept got stall=%b want 0", bus.stall); end
        @(negedge clk); bus.pix_valid = 1'b0; #1;
        n_tests++; if (bus.stall !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL frz_enter got stall=%b valid=%b want 1 1", bus.stall, bus.out_valid); end
        repeat (3) @(negedge clk);
        n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL frz_hold_stall got %b want 1", bus.stall); end
        n_tests++; if (bus.out_psum !== e1 || bus.out_group_idx !== 16'd0) begin
            n_fail++; $display("FAIL frz_hold_data got idx=%0d psum=%h want 0 %h", bus.out_group_idx, bus.out_psum, e1); end
        bus.out_ready = 1'b1; #1;
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL frz_release_stall got %b want 0", bus.stall); end
        @(negedge clk);
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_psum !== e2 || bus.out_group_idx !== 16'd1) begin
            n_fail++; $display("FAIL frz_second got valid=%b idx=%0d psum=%h want 1 1 %h", bus.out_valid, bus.out_group_idx, bus.out_psum, e2); end
        @(negedge clk);
        n_tests++; if (bus.out_valid !== 1'b0 || bus.out_group_idx !== 16'd2) begin
            n_fail++; $display("FAIL frz_drain got valid=%b idx=%0d want 0 2", bus.out_valid, bus.out_group_idx); end
    endtask

    task automatic test_wrap();
        logic [NP*PW-1:0] e;
        int stalled = 0;
        int t = 0;
        pulse_start(3, 300);
        bus.out_ready = 1'b1;
        fill(255, 127); clear_acc();
        for (int b = 0; b < 300; b++) begin
            @(negedge clk); load_bus(); bus.pix_valid = 1'b1; #1;
            if (bus.stall) stalled++;
            model_add(3);
        end
        e = pack_exp();
        @(negedge clk); bus.pix_valid = 1'b0;
        while (!bus.out_valid && t < 6) begin @(negedge clk); t++; end
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_timeout got valid=%b want 1", bus.out_valid); end
        n_tests++; if (bus.out_psum !== e) begin n_fail++; $display("FAIL wrap_psum got %h want %h", bus.out_psum, e); end
`ifdef CONV_MAC_PSUM_SAT_EN
        n_tests++; if (bus.out_psum[0+:PW] !== 24'd8388607) begin n_fail++; $display("FAIL sat_lane0 got %0d want 8388607", bus.out_psum[0+:PW]); end
`else
        n_tests++; if (bus.out_psum[0+:PW] !== 24'd3553420) begin n_fail++; $display("FAIL wrap_lane0 got %0d want 3553420", bus.out_psum[0+:PW]); end
`endif
        n_tests++; if (stalled != 0) begin n_fail++; $display("FAIL wrap_stall got %0d want 0", stalled); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [NP*PW-1:0] e;
        int t = 0;
        pulse_start(3, 4);
        bus.out_ready = 1'b0;
        for (int b = 0; b < 6; b++) begin
            rand_pix();
            for (int r = 0; r < 3; r++) for (int j = 0; j < NP; j++) pix[r][j] = (pix[r][j] % 255) + 1;
            for (int i = 0; i < 9; i++) wt[i] = (wt[i] + 128) % 127 + 1;
            @(negedge clk); load_bus(); bus.pix_valid = 1'b1;
        end
        @(negedge clk); bus.pix_valid = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rmid_pre got valid=%b busy=%b want 1 1", bus.out_valid, busy); end
        #2 reset = 1'b1; #1;
        n_tests++; if (bus.out_valid !== 1'b0 || bus.out_psum !== '0 || bus.out_group_idx !== 16'd0 || busy !== 1'b0 || bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL rmid_clear got valid=%b idx=%0d busy=%b stall=%b psum=%h want all 0",
                               bus.out_valid, bus.out_group_idx, busy, bus.stall, bus.out_psum); end
        @(negedge clk); reset = 1'b0; bus.out_ready = 1'b1;
        pulse_start(3, 4);
        clear_acc();
        for (int b = 0; b < 4; b++) begin
            rand_pix(); @(negedge clk); load_bus(); bus.pix_valid = 1'b1; model_add(3);
        end
        e = pack_exp();
        @(negedge clk); bus.pix_valid = 1'b0;
        while (!bus.out_valid && t < 6) begin @(negedge clk); t++; end
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_psum !== e || bus.out_group_idx !== 16'd0) begin
            n_fail++; $display("FAIL rmid_fresh got valid=%b idx=%0d psum=%h want 1 0 %h", bus.out_valid, bus.out_group_idx, bus.out_psum, e); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int cfg_k [5] = '{1, 3, 0, 7, 15};
        for (int cfg = 0; cfg < 4; cfg++) begin
            logic [NP*PW-1:0] q [$];
            logic [NP*PW-1:0] e;
            int kk, nn, nn_eff, total;
            int beats = 0, cnt = 0, idx = 0, guard = 0;
            logic pend = 1'b0;
            kk = cfg_k[$urandom_range(4, 0)];
            nn = (cfg == 0) ? 0 : int'($urandom_range(6, 1));
            nn_eff = (nn == 0) ? 1 : nn;
            total = 3 * nn_eff;
            pulse_start(kk, nn);
            clear_acc();
            while ((beats < total || q.size() != 0) && guard < 600) begin
                @(negedge clk); guard++;
                en = ($urandom_range(7, 0) != 0);
                bus.out_ready = ($urandom_range(3, 0) != 0);
                if (!pend && beats < total && $urandom_range(3, 0) != 0) begin
                    rand_pix(); load_bus(); bus.pix_valid = 1'b1; pend = 1'b1;
                end else if (!pend) begin
                    bus.pix_valid = 1'b0;
                end
                #1;
                if (en && bus.out_valid && bus.out_ready) begin
                    n_tests++;
                    if (q.size() == 0) begin
                        n_fail++; $display("FAIL rnd_unexpected got idx=%0d want no output", bus.out_group_idx);
                    end else begin
                        e = q.pop_front();
                        if (bus.out_psum !== e || bus.out_group_idx !== 16'(idx)) begin
                            n_fail++; $display("FAIL rnd_group k=%0d nif=%0d got idx=%0d psum=%h want %0d %h",
                                               kk, nn, bus.out_group_idx, bus.out_psum, idx, e);
                        end
                        idx++;
                    end
                end
                if (pend && en && !bus.stall) begin
                    model_add(kk); beats++; cnt++; pend = 1'b0;
                    if (cnt == nn_eff) begin q.push_back(pack_exp()); clear_acc(); cnt = 0; end
                end
            end
            @(negedge clk); en = 1'b1; bus.pix_valid = 1'b0;
            n_tests++; if (guard >= 600) begin n_fail++; $display("FAIL rnd_timeout got %0d pending groups want 0", q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_k3_ones();
        test_k3_neg();
        test_k1();
        test_freeze();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end
endmodule

// File: doc/conv_window_mac.md
Name: conv_window_mac

Overview:
- Directly downstream of the convolution front-end datapath.
- Consumes the three re-ordered pixel rows (re_row1/2/3_pixels) once per input-channel beat.
- Multiplies each 3x3 (or 1x1) column window by per-channel signed weights and accumulates partial sums across all nif input channels.
- Presents one accumulated row of partial sums per channel group to the post-processing stage through a valid/ready output register, and back-pressures the front-end via stall.

Parameters:
- pixels_in_row, 32, pixels per row bus and number of psum lanes
- psum_width, 24, bits per accumulated partial sum (signed)
- weight_width, 8, bits per signed weight

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  1  global enable; when 0 all state frozen, stall forced 0
- k  input  4  kernel size; 1 or 3 legal, any other value treated as 3
- nif  input  16  input channels per group; 0 treated as 1
- start  input  1  synchronous clear of counters, pipeline, accumulators and out_valid (psum lanes zeroed)
- pix_valid  input  1  row buses and weights carry a valid channel beat
- re_row1_pixels / re_row2_pixels / re_row3_pixels  input  pixels_in_row*8 each  unsigned pixels; pixel j at [j*8+:8]
- weights  input  9*weight_width  signed; w[r*3+c] at [(r*3+c)*weight_width+:weight_width], r=0..2 maps to row1..row3
- stall  output  1  beat not accepted this cycle; upstream must hold
- out_valid  output  1  out_psum holds a completed group
- out_ready  input  1  consumer accepts out_psum when out_valid=1
- out_psum  output  pixels_in_row*psum_width  lane j at [j*psum_width+:psum_width], signed
- out_group_idx  output  16  groups emitted since reset/start (value for current out_psum)
- busy  output  1  stage A valid or channel count nonzero

Behaviour:
- Reset: stall=0, out_valid=0, out_psum=0, out_group_idx=0, busy=0, channel count=0, all lanes 0.
- Accept: pix_valid & en & !stall at a rising edge.
- Stage A (edge of accept): per lane j, window sum registered together with a_last = (chan_cnt==nif-1) and a_first = (chan_cnt==0).
  - k=3, j<=pixels_in_row-3: sum over r,c of pixel(row r+1, j+c) * w[r*3+c].
  - k=3, upper two lanes: 0.
  - k=1: pixel(row1, j) * w[0] for all lanes.
  - Pixels zero-extended to 9-bit signed; window sum is 21-bit signed, sign-extended to psum_width.
- Stage B (next edge):
  - Accumulator lane <= (a_first ? 0 : acc) + sum.
  - If a_last: out_psum <= that result, out_valid <= 1, out_group_idx increments after handover, accumulator cleared.
- chan_cnt: increments per accepted beat; wraps to 0 after nif-1.
- Latency: accept edge E0 -> out_valid high after E1 for a last beat. Throughput 1 beat/cycle.
- Output handshake: out_valid falls on the edge where out_valid & out_ready, unless a new group loads the same edge (then stays 1 with new data).
- Freeze: a_last beat in stage A while out_valid & !out_ready -> stage A and B hold.
- stall = en & a_valid & a_last & out_valid & !out_ready (combinational).
- Arithmetic: default wraps modulo 2^psum_width.
- Simultaneous events:
  - start overrides accept and out handshake.
  - reset mid-group discards partial sums.
  - nif changes take effect only after the next start.

Optional Feature:
- Macro CONV_MAC_PSUM_SAT_EN.
- Defined: stage B addition saturates to [-2^(psum_width-1), 2^(psum_width-1)-1].
- Undefined: two's-complement wrap.

Test Plan:
- k=3, nif=1, all pixels 1, all weights 1, out_ready=1 -> out_valid after 2 edges; lanes 0..29 = 9, lanes 30..31 = 0, out_group_idx 0 then 1.
- k=3, nif=4, pixels 2, weights -3, back-to-back beats -> single output, lanes 0..29 = -216, stall never asserted.
- k=1, nif=2, pixel j = j, w[0]=5 -> lane j = 10*j, no stall.
- Two groups with nif=1, out_ready=0 -> second last beat freezes, stall=1 held; raise out_ready -> first group drained, second loaded next edge, stall drops.
- Wrap/saturate: psum_width=24, pixels 255, weights 127, nif=300 -> undefined macro gives modulo value; macro defined gives 8388607.
- Assert reset after 2 of 4 channel beats -> all outputs 0 immediately; fresh 4-beat group matches expected sums with no residue.
